// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: writeback-stage commit controller. It accepts one retiring
// instruction per cycle and decides whether it raises an interrupt, raises an
// exception, executes ertn or writes a CSR. The CSR-file strobes are driven as
// registered single-cycle pulses. For flushing events it then sequences the
// pipeline flush and the refetch handshake before the next retirement is
// accepted.
module exc_commit_ctrl #(
    parameter int CSR_NUM_WIDTH = 14,
    parameter int DRAIN_MIN     = 2
) (
    input  logic                     clk,
    input  logic                     resetn,

    // retiring instruction from writeback
    input  logic                     ws_valid,
    output logic                     ws_ready,
    input  logic [31:0]              ws_pc,
    input  logic                     ws_ex,
    input  logic [5:0]               ws_ecode,
    input  logic [8:0]               ws_esubcode,
    input  logic [31:0]              ws_vaddr,
    input  logic                     ws_ertn,
    input  logic                     ws_csr_we,
    input  logic [CSR_NUM_WIDTH-1:0] ws_csr_num,
    input  logic [31:0]              ws_csr_wmask,
    input  logic [31:0]              ws_csr_wvalue,

    // interrupt state read from the CSR file
    input  logic [12:0]              csr_estat_is,
    input  logic [12:0]              csr_ecfg_lie,
    input  logic                     csr_crmd_ie,

    // update strobes toward the CSR file
    output logic                     wb_ex,
    output logic [31:0]              wb_pc,
    output logic [31:0]              wb_vaddr,
    output logic [5:0]               wb_ecode,
    output logic [8:0]               wb_esubcode,
    output logic                     ertn_flush,
    output logic                     csr_we,
    output logic [CSR_NUM_WIDTH-1:0] csr_num,
    output logic [31:0]              csr_wmask,
    output logic [31:0]              csr_wvalue,
    output logic                     csr_busy,

    // flush / refetch handshake
    output logic                     pipe_flush,
    input  logic                     if_flush_ack
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    // The counter only has to hold DRAIN_MIN-1, and it counts down to 0.
    localparam int CNT_W = (DRAIN_MIN > 1) ? $clog2(DRAIN_MIN) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_MIN - 1);

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;
    logic             ack_seen;   // a refetch ack that arrived before the counter reached 0

    logic int_pend;
    logic accept;
    logic take_int;
    logic take_ex;
    logic take_ertn;
    logic take_csr;
    logic drain_done;

    // The interrupt is evaluated in the accept cycle. It pre-empts the
    // retiring instruction, so that instruction is never committed.
    assign int_pend  = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
    assign accept    = ws_valid & (state == ST_RUN);
    assign take_int  = accept & int_pend;
    assign take_ex   = accept & ~int_pend & ws_ex;
    assign take_ertn = accept & ~int_pend & ~ws_ex & ws_ertn;
    assign take_csr  = accept & ~int_pend & ~ws_ex & ~ws_ertn & ws_csr_we;

    // DRAIN can exit only when the minimum dwell time is over and fetch has
    // redirected: the ack is either present now or was latched earlier.
    assign drain_done = (drain_cnt == '0) & (ack_seen | if_flush_ack);

    // Outside RUN, any instruction presented is a younger one that the flush
    // cancels, so it is not accepted.
    assign ws_ready = (state == ST_RUN);

    // The three strobes are mutually exclusive, so their OR marks the one
    // cycle in which the CSR file is being updated.
    assign csr_busy = wb_ex | ertn_flush | csr_we;

    // Commit FSM: registered strobes and data, flush sequencing and drain counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the reset is synchronous (tested inside the clocked block),
            // so a reset during FLUSH/DRAIN takes effect at the next edge and
            // leaves no pulse behind.
            state       <= ST_RUN;
            drain_cnt   <= '0;
            ack_seen    <= 1'b0;
            wb_ex       <= 1'b0;
            ertn_flush  <= 1'b0;
            csr_we      <= 1'b0;
            pipe_flush  <= 1'b0;
            wb_pc       <= '0;
            wb_vaddr    <= '0;
            wb_ecode    <= '0;
            wb_esubcode <= '0;
            csr_num     <= '0;
            csr_wmask   <= '0;
            csr_wvalue  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // decision in this block uses the value from before the edge.
            // The defaults below make each strobe last exactly one cycle and
            // return the data buses to 0 when no strobe is active.
            wb_ex       <= 1'b0;
            ertn_flush  <= 1'b0;
            csr_we      <= 1'b0;
            pipe_flush  <= 1'b0;
            wb_pc       <= '0;
            wb_vaddr    <= '0;
            wb_ecode    <= '0;
            wb_esubcode <= '0;
            csr_num     <= '0;
            csr_wmask   <= '0;
            csr_wvalue  <= '0;

            case (state)
                ST_RUN: begin
                    if (take_int) begin
                        wb_ex      <= 1'b1;
                        wb_pc      <= ws_pc;
                        pipe_flush <= 1'b1;
                        ack_seen   <= 1'b0;
                        state      <= ST_FLUSH;
                    end else if (take_ex) begin
                        wb_ex       <= 1'b1;
                        wb_pc       <= ws_pc;
                        wb_vaddr    <= ws_vaddr;
                        wb_ecode    <= ws_ecode;
                        wb_esubcode <= ws_esubcode;
                        pipe_flush  <= 1'b1;
                        ack_seen    <= 1'b0;
                        state       <= ST_FLUSH;
                    end else if (take_ertn) begin
                        ertn_flush <= 1'b1;
                        pipe_flush <= 1'b1;
                        ack_seen   <= 1'b0;
                        state      <= ST_FLUSH;
                    end else if (take_csr) begin
                        // A plain CSR write does not flush, so retirement continues.
                        csr_we     <= 1'b1;
                        csr_num    <= ws_csr_num;
                        csr_wmask  <= ws_csr_wmask;
                        csr_wvalue <= ws_csr_wvalue;
                    end
                end

                ST_FLUSH: begin
                    drain_cnt <= DRAIN_LOAD;
                    ack_seen  <= if_flush_ack;
                    state     <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    if (drain_done) begin
                        ack_seen <= 1'b0;
                        state    <= ST_RUN;
                    end else begin
                        if (drain_cnt != '0) begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                        if (if_flush_ack) begin
                            ack_seen <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Testbench for exc_commit_ctrl. A table of single-accept vectors covers the
// priority decode. Hand-written sequences then cover reset, back-to-back CSR
// writes, flush and drain timing, a deferred interrupt and reset during DRAIN.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid;
    logic        ws_ready;
    logic [31:0] ws_pc;
    logic        ws_ex;
    logic [5:0]  ws_ecode;
    logic [8:0]  ws_esubcode;
    logic [31:0] ws_vaddr;
    logic        ws_ertn;
    logic        ws_csr_we;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_csr_wmask;
    logic [31:0] ws_csr_wvalue;
    logic [12:0] csr_estat_is;
    logic [12:0] csr_ecfg_lie;
    logic        csr_crmd_ie;
    logic        wb_ex;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        ertn_flush;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        csr_busy;
    logic        pipe_flush;
    logic        if_flush_ack;

    int n_tests = 0;
    int n_fail  = 0;

    exc_commit_ctrl #(.CSR_NUM_WIDTH(14), .DRAIN_MIN(2)) dut (
        .clk(clk), .resetn(resetn),
        .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc),
        .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
        .ws_vaddr(ws_vaddr), .ws_ertn(ws_ertn), .ws_csr_we(ws_csr_we),
        .ws_csr_num(ws_csr_num), .ws_csr_wmask(ws_csr_wmask),
        .ws_csr_wvalue(ws_csr_wvalue),
        .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie),
        .csr_crmd_ie(csr_crmd_ie),
        .wb_ex(wb_ex), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .ertn_flush(ertn_flush), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_busy(csr_busy), .pipe_flush(pipe_flush), .if_flush_ack(if_flush_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        // stimulus
        logic        valid, ex, ertn, cwe, ie;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc, vaddr;
        logic [13:0] num;
        logic [31:0] mask, value;
        logic [12:0] is, lie;
        // expected one cycle after the accept
        logic        e_wb_ex, e_ertn, e_csr_we, e_flush;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
        logic [31:0] e_pc, e_vaddr;
        logic [13:0] e_num;
        logic [31:0] e_mask, e_value;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ws_valid = 0; ws_pc = 0; ws_ex = 0; ws_ecode = 0; ws_esubcode = 0;
        ws_vaddr = 0; ws_ertn = 0; ws_csr_we = 0; ws_csr_num = 0;
        ws_csr_wmask = 0; ws_csr_wvalue = 0;
        csr_estat_is = 0; csr_ecfg_lie = 0; csr_crmd_ie = 0;
    endtask

    task automatic check_strobes(input string tag, input logic ex, input logic er,
                                 input logic we, input logic fl);
        check({tag, ".wb_ex"}, 32'(wb_ex), 32'(ex));
        check({tag, ".ertn_flush"}, 32'(ertn_flush), 32'(er));
        check({tag, ".csr_we"}, 32'(csr_we), 32'(we));
        check({tag, ".pipe_flush"}, 32'(pipe_flush), 32'(fl));
        check({tag, ".csr_busy"}, 32'(csr_busy), 32'(ex | er | we));
    endtask

    // Hold the ack high until ws_ready returns. The wait is bounded, and an
    // expired bound is reported as a failed comparison.
    task automatic recover(input string tag);
        int k = 0;
        if_flush_ack = 1;
        while (!ws_ready && k < 20) begin
            step();
            k++;
        end
        if_flush_ack = 0;
        check({tag, ".recover_ready"}, 32'(ws_ready), 32'd1);
    endtask

    initial begin
        // ---------------- vector table ----------------
        for (int i = 0; i < NVEC; i++) vec[i] = '0;
        // 0: plain CSR write
        vec[0].valid = 1; vec[0].cwe = 1; vec[0].num = 14'h30;
        vec[0].mask = 32'hFFFFFFFF; vec[0].value = 32'hDEADBEEF;
        vec[0].e_csr_we = 1; vec[0].e_num = 14'h30;
        vec[0].e_mask = 32'hFFFFFFFF; vec[0].e_value = 32'hDEADBEEF;
        // 1: synchronous exception
        vec[1].valid = 1; vec[1].ex = 1; vec[1].ecode = 6'h08; vec[1].esub = 9'd1;
        vec[1].pc = 32'h1C000100; vec[1].vaddr = 32'h1234;
        vec[1].e_wb_ex = 1; vec[1].e_flush = 1; vec[1].e_ecode = 6'h08;
        vec[1].e_esub = 9'd1; vec[1].e_pc = 32'h1C000100; vec[1].e_vaddr = 32'h1234;
        // 2: interrupt beats exception and CSR write
        vec[2].valid = 1; vec[2].ex = 1; vec[2].cwe = 1; vec[2].ecode = 6'h08;
        vec[2].esub = 9'd3; vec[2].pc = 32'h1C000200; vec[2].vaddr = 32'h5555;
        vec[2].num = 14'h6; vec[2].mask = 32'hFFFFFFFF; vec[2].value = 32'h77;
        vec[2].is = 13'h800; vec[2].lie = 13'h800; vec[2].ie = 1;
        vec[2].e_wb_ex = 1; vec[2].e_flush = 1; vec[2].e_pc = 32'h1C000200;
        // 3: same interrupt but globally masked -> CSR write
        vec[3].valid = 1; vec[3].cwe = 1; vec[3].pc = 32'h1C000300;
        vec[3].num = 14'h6; vec[3].mask = 32'h0000FFFF; vec[3].value = 32'hA5A5;
        vec[3].is = 13'h800; vec[3].lie = 13'h800; vec[3].ie = 0;
        vec[3].e_csr_we = 1; vec[3].e_num = 14'h6;
        vec[3].e_mask = 32'h0000FFFF; vec[3].e_value = 32'hA5A5;
        // 4: ertn beats CSR write
        vec[4].valid = 1; vec[4].ertn = 1; vec[4].cwe = 1; vec[4].num = 14'h1;
        vec[4].mask = 32'hFFFFFFFF; vec[4].value = 32'h9;
        vec[4].e_ertn = 1; vec[4].e_flush = 1;
        // 5: exception beats ertn and CSR write
        vec[5].valid = 1; vec[5].ex = 1; vec[5].ertn = 1; vec[5].cwe = 1;
        vec[5].ecode = 6'h0B; vec[5].esub = 9'd0; vec[5].pc = 32'h1C000500;
        vec[5].vaddr = 32'hCAFE0000;
        vec[5].e_wb_ex = 1; vec[5].e_flush = 1; vec[5].e_ecode = 6'h0B;
        vec[5].e_pc = 32'h1C000500; vec[5].e_vaddr = 32'hCAFE0000;
        // 6: ordinary instruction -> no strobe
        vec[6].valid = 1; vec[6].pc = 32'h1C000600;
        // 7: CSR write without valid -> ignored
        vec[7].cwe = 1; vec[7].num = 14'h30; vec[7].mask = 32'hFFFFFFFF; vec[7].value = 32'h1;
        // 8: interrupt pending but not enabled locally -> CSR write
        vec[8].valid = 1; vec[8].cwe = 1; vec[8].num = 14'h3FFF;
        vec[8].mask = 32'h80000001; vec[8].value = 32'hFFFFFFFF;
        vec[8].is = 13'h001; vec[8].lie = 13'h002; vec[8].ie = 1;
        vec[8].e_csr_we = 1; vec[8].e_num = 14'h3FFF;
        vec[8].e_mask = 32'h80000001; vec[8].e_value = 32'hFFFFFFFF;

        // ---------------- reset with pending CSR write ----------------
        idle_inputs();
        if_flush_ack = 0;
        resetn = 0;
        ws_valid = 1; ws_csr_we = 1; ws_csr_num = 14'h30;
        ws_csr_wmask = 32'hFFFFFFFF; ws_csr_wvalue = 32'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_strobes($sformatf("rst%0d", i), 0, 0, 0, 0);
        end
        check("rst.csr_wvalue", csr_wvalue, 32'h0);
        check("rst.wb_pc", wb_pc, 32'h0);
        idle_inputs();
        resetn = 1;
        step();
        check("rst.ws_ready", 32'(ws_ready), 32'd1);
        check_strobes("rst_rel", 0, 0, 0, 0);

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            ws_valid = vec[i].valid; ws_ex = vec[i].ex; ws_ertn = vec[i].ertn;
            ws_csr_we = vec[i].cwe; ws_ecode = vec[i].ecode; ws_esubcode = vec[i].esub;
            ws_pc = vec[i].pc; ws_vaddr = vec[i].vaddr; ws_csr_num = vec[i].num;
            ws_csr_wmask = vec[i].mask; ws_csr_wvalue = vec[i].value;
            csr_estat_is = vec[i].is; csr_ecfg_lie = vec[i].lie; csr_crmd_ie = vec[i].ie;
            step();
            idle_inputs();
            check_strobes(t, vec[i].e_wb_ex, vec[i].e_ertn, vec[i].e_csr_we, vec[i].e_flush);
            check({t, ".ws_ready"}, 32'(ws_ready), 32'(!vec[i].e_flush));
            check({t, ".wb_vaddr"}, wb_vaddr, vec[i].e_vaddr);
            if (vec[i].e_wb_ex) begin
                check({t, ".wb_pc"}, wb_pc, vec[i].e_pc);
                check({t, ".wb_ecode"}, 32'(wb_ecode), 32'(vec[i].e_ecode));
                check({t, ".wb_esubcode"}, 32'(wb_esubcode), 32'(vec[i].e_esub));
            end
            if (vec[i].e_csr_we) begin
                check({t, ".csr_num"}, 32'(csr_num), 32'(vec[i].e_num));
                check({t, ".csr_wmask"}, csr_wmask, vec[i].e_mask);
                check({t, ".csr_wvalue"}, csr_wvalue, vec[i].e_value);
            end
            recover(t);
        end

        // ---------------- back-to-back CSR writes ----------------
        ws_valid = 1; ws_csr_we = 1; ws_csr_num = 14'h30;
        ws_csr_wmask = 32'hFFFFFFFF; ws_csr_wvalue = 32'hDEADBEEF;
        step();
        check_strobes("b2b0", 0, 0, 1, 0);
        check("b2b0.csr_wvalue", csr_wvalue, 32'hDEADBEEF);
        check("b2b0.ws_ready", 32'(ws_ready), 32'd1);
        ws_csr_num = 14'h31; ws_csr_wmask = 32'h00FF00FF; ws_csr_wvalue = 32'h12345678;
        step();
        check_strobes("b2b1", 0, 0, 1, 0);
        check("b2b1.csr_num", 32'(csr_num), 32'h31);
        check("b2b1.csr_wmask", csr_wmask, 32'h00FF00FF);
        check("b2b1.csr_wvalue", csr_wvalue, 32'h12345678);
        idle_inputs();
        step();
        check_strobes("b2b2", 0, 0, 0, 0);

        // ---------------- exception with early ack: RUN again at T+4 ----------------
        ws_valid = 1; ws_ex = 1; ws_ecode = 6'h08; ws_esubcode = 9'd1;
        ws_pc = 32'h1C000100; ws_vaddr = 32'h1234;
        step();                                   // T+1
        check_strobes("exq1", 1, 0, 0, 1);
        check("exq1.ws_ready", 32'(ws_ready), 32'd0);
        // A younger CSR write is presented during the flush and must be dropped.
        idle_inputs();
        ws_valid = 1; ws_csr_we = 1; ws_csr_num = 14'h5; ws_csr_wmask = 32'hFFFFFFFF;
        ws_csr_wvalue = 32'hBAD0BAD0;
        step();                                   // T+2
        check_strobes("exq2", 0, 0, 0, 0);
        check("exq2.ws_ready", 32'(ws_ready), 32'd0);
        if_flush_ack = 1;
        step();                                   // T+3
        if_flush_ack = 0;
        check_strobes("exq3", 0, 0, 0, 0);
        check("exq3.ws_ready", 32'(ws_ready), 32'd0);
        step();                                   // T+4
        check("exq4.ws_ready", 32'(ws_ready), 32'd1);
        check_strobes("exq4", 0, 0, 0, 0);
        step();                                   // accept of the held CSR write
        check_strobes("exq5", 0, 0, 1, 0);
        check("exq5.csr_wvalue", csr_wvalue, 32'hBAD0BAD0);
        idle_inputs();
        step();

        // ---------------- no ack: DRAIN holds; interrupt deferred until RUN ----------------
        ws_valid = 1; ws_ertn = 1;
        step();
        check_strobes("nack1", 0, 1, 0, 1);
        idle_inputs();
        ws_valid = 1; ws_csr_we = 1; ws_pc = 32'h1C000900;
        csr_estat_is = 13'h004; csr_ecfg_lie = 13'h004; csr_crmd_ie = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_strobes($sformatf("nack_d%0d", i), 0, 0, 0, 0);
            check($sformatf("nack_d%0d.ws_ready", i), 32'(ws_ready), 32'd0);
        end
        if_flush_ack = 1;
        step();
        if_flush_ack = 0;
        check("nack.ws_ready", 32'(ws_ready), 32'd1);
        step();
        check_strobes("defint", 1, 0, 0, 1);
        check("defint.wb_ecode", 32'(wb_ecode), 32'h0);
        check("defint.wb_pc", wb_pc, 32'h1C000900);
        idle_inputs();
        recover("defint");

        // ---------------- ertn then reset during DRAIN ----------------
        ws_valid = 1; ws_ertn = 1;
        step();
        check_strobes("er1", 0, 1, 0, 1);
        idle_inputs();
        step();
        check_strobes("er2", 0, 0, 0, 0);
        check("er2.ws_ready", 32'(ws_ready), 32'd0);
        resetn = 0;
        step();
        check("er_rst.ws_ready", 32'(ws_ready), 32'd1);
        check_strobes("er_rst", 0, 0, 0, 0);
        resetn = 1;
        step();
        check("er_post.ws_ready", 32'(ws_ready), 32'd1);
        check_strobes("er_post", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Initiator side of the CSR file's update interface.
- Sits at the end of the writeback stage. It takes one retiring instruction per cycle and arbitrates interrupt, exception, ertn and CSR-write events.
- Drives the CSR file's wb_ex / ertn_flush / csr_we strobe group as registered single-cycle pulses, then sequences the pipeline flush and refetch handshake before accepting new retirements.

Parameters:
- CSR_NUM_WIDTH, 14: CSR number width.
- DRAIN_MIN, 2: minimum cycles spent in DRAIN after a flush.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ws_valid  in  1  retiring instruction present.
- ws_ready  out  1  instruction accepted this cycle (=1 only in RUN).
- ws_pc  in  32  retiring PC.
- ws_ex  in  1  instruction carries a synchronous exception.
- ws_ecode  in  6  its ecode.
- ws_esubcode  in  9  its esubcode.
- ws_vaddr  in  32  faulting data address.
- ws_ertn  in  1  instruction is ertn.
- ws_csr_we  in  1  instruction writes a CSR.
- ws_csr_num  in  CSR_NUM_WIDTH  target CSR.
- ws_csr_wmask  in  32  write mask (all-ones for csrwr).
- ws_csr_wvalue  in  32  write data.
- csr_estat_is  in  13  pending interrupt status.
- csr_ecfg_lie  in  13  interrupt enables.
- csr_crmd_ie  in  1  global interrupt enable.
- wb_ex  out  1  exception strobe to CSR file.
- wb_pc  out  32  PC for ERA.
- wb_vaddr  out  32  address for BADV.
- wb_ecode  out  6  ecode.
- wb_esubcode  out  9  esubcode.
- ertn_flush  out  1  ertn strobe.
- csr_we  out  1  CSR write strobe.
- csr_num  out  CSR_NUM_WIDTH  CSR number.
- csr_wmask  out  32  CSR write mask.
- csr_wvalue  out  32  CSR write data.
- csr_busy  out  1  a registered CSR write/ex/ertn is pending (decode must stall CSR reads).
- pipe_flush  out  1  flush all younger stages.
- if_flush_ack  in  1  fetch has redirected to the new PC.

Behaviour:
- Reset (resetn=0 at posedge):
  - state goes to RUN.
  - wb_ex, ertn_flush, csr_we, pipe_flush and csr_busy are 0.
  - All data outputs are 0.
  - Drain counter is 0.
  - Reset mid-FLUSH/DRAIN abandons the sequence with no strobes.
- int_pend = csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie), evaluated combinationally in the accept cycle.
- Accept occurs when ws_valid & state==RUN. Accept cycle T, strobes in T+1 (1-cycle latency); the CSR file captures at the end of T+1.
- Priority at accept:
  1. int_pend: wb_ex=1, ecode=0x00, esubcode=0, wb_pc=ws_pc. The instruction is not committed: its csr write, ertn and ex are suppressed.
  2. ws_ex: wb_ex=1, ecode/esubcode/vaddr/pc from ws_*; CSR write suppressed.
  3. ws_ertn: ertn_flush=1; CSR write suppressed.
  4. ws_csr_we: csr_we=1 with num/mask/value registered; no flush; state stays RUN.
  5. Otherwise: no strobe.
- Strobe rules:
  - At most one of wb_ex, ertn_flush and csr_we is high in any cycle.
  - Each strobe is exactly 1 cycle.
  - csr_busy equals the OR of the three strobes.
- FSM:
  - RUN→FLUSH on accept of case 1, 2 or 3.
  - FLUSH lasts one cycle, coincides with the strobe, and has pipe_flush=1.
  - FLUSH→DRAIN with counter loaded to DRAIN_MIN-1.
  - DRAIN: counter decrements to 0 and saturates there. Exit to RUN when counter==0 and if_flush_ack=1 is sampled at the same posedge; an ack arriving earlier is latched (sticky) and satisfies the exit.
  - ws_ready=0 in FLUSH and DRAIN; ws_valid there is ignored (instruction cancelled by flush).
- Back-to-back CSR writes are accepted every cycle in RUN; csr_we stays high across consecutive cycles with per-cycle data.
- An interrupt arriving while not in RUN is taken on the first accept after returning to RUN.
- wb_vaddr is held 0 when the strobe is not case 2.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with ws_valid=1, ws_csr_we=1 → all strobes 0 and ws_ready=1 after release.
- CSR write: ws_csr_we=1, num=0x30, mask=FFFFFFFF, value=0xDEADBEEF at T → csr_we=1 with those values at T+1 only, pipe_flush=0; the following instruction is accepted at T+1.
- Exception: ws_ex=1, ecode=0x08, esub=1, pc=0x1C000100, vaddr=0x1234 → wb_ex=1 at T+1 with those values, pipe_flush=1 at T+1, ws_ready=0 until the ack. Ack at T+2 is held until the counter reaches 0, giving RUN at T+4 with DRAIN_MIN=2.
- Interrupt priority: estat_is=0x800, lie=0x800, ie=1, plus ws_ex=1 and ws_csr_we=1 → wb_ex with ecode 0 and esub 0, csr_we=0, wb_pc=ws_pc.
- Masked interrupt: same setup with ie=0 → no interrupt; csr_we path taken.
- Ertn plus reset: ws_ertn=1 → ertn_flush at T+1; resetn=0 during DRAIN → RUN next cycle with no further strobes and no stuck ws_ready=0.
